// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA timing engine.
//   rgb_t     : one pixel, R/G/B channels of COLOR_W_DFLT bits
//   vga_ctl_t : raster control flags carried through the latency pipeline
//   bar_color : per-channel on/off pattern of the eight test colour bars
package vga_pkg;

    localparam int unsigned COLOR_W_DFLT = 8;
    localparam int unsigned NUM_BARS     = 8;

    typedef struct packed {
        logic [COLOR_W_DFLT-1:0] r;
        logic [COLOR_W_DFLT-1:0] g;
        logic [COLOR_W_DFLT-1:0] b;
    } rgb_t;

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic fs;
    } vga_ctl_t;

    // Bar colours as {r, g, b} full-scale enables, left to right.
    localparam logic [2:0] BAR_WHITE   = 3'b111;
    localparam logic [2:0] BAR_YELLOW  = 3'b110;
    localparam logic [2:0] BAR_CYAN    = 3'b011;
    localparam logic [2:0] BAR_GREEN   = 3'b010;
    localparam logic [2:0] BAR_MAGENTA = 3'b101;
    localparam logic [2:0] BAR_RED     = 3'b100;
    localparam logic [2:0] BAR_BLUE    = 3'b001;
    localparam logic [2:0] BAR_BLACK   = 3'b000;

    function automatic logic [2:0] bar_color(input logic [2:0] idx);
        logic [2:0] c;
        c = BAR_BLACK;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis (horizontal or vertical): sync, back porch, active, front porch.
//   iCLK, iRST_N : clock, async active-low reset
//   tick         : advance the count by one
//   clear        : synchronous return to 0 (has priority over tick)
//   cnt          : current position 0..TOT-1
//   wrap         : tick on the last position (combinational)
//   active       : cnt inside the active window (combinational)
//   sync_raw     : cnt inside the sync pulse, polarity-free (combinational)
module vga_axis_counter #(
    parameter int unsigned SYNC  = 1,
    parameter int unsigned BACK  = 1,
    parameter int unsigned ACT   = 1,
    parameter int unsigned FRONT = 1,
    parameter int unsigned W     = 12
) (
    input  logic         iCLK,
    input  logic         iRST_N,
    input  logic         tick,
    input  logic         clear,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         active,
    output logic         sync_raw
);

    localparam int unsigned TOT    = SYNC + BACK + ACT + FRONT;
    localparam int unsigned ACT_LO = SYNC + BACK;
    localparam int unsigned ACT_HI = ACT_LO + ACT;

    assign wrap     = tick && (cnt == W'(TOT - 1));
    assign active   = (cnt >= W'(ACT_LO)) && (cnt < W'(ACT_HI));
    assign sync_raw = (cnt < W'(SYNC));

    // Position counter; wraps straight from TOT-1 to 0.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            cnt <= '0;
        end else if (clear || wrap) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_engine.sv
// VGA raster timing engine with pixel-request lookahead.
// oREQ/oX/oY run RD_LAT+1 cycles ahead of the pins so that host pixels,
// returned RD_LAT cycles after the request, land on the registered outputs
// together with their own sync/blank.
// Optional feature macro: VGA_TEST_PATTERN_EN adds iPATTERN (colour bars).
//   iCLK, iRST_N          : pixel clock, async active-low reset
//   iEN                   : raster enable (low holds counters at 0)
//   iRed/iGreen/iBlue     : host pixel, valid RD_LAT cycles after oREQ
//   oREQ, oX, oY          : combinational pixel request and coordinate
//   oVGA_R/G/B            : registered colour, 0 when blanked
//   oVGA_H_SYNC/V_SYNC    : registered syncs
//   oVGA_BLANK            : registered, 1 = active video
//   oVGA_SYNC, oVGA_CLK   : constant 0, inverted pixel clock
//   oFRAME_START          : one-cycle pulse on the first pin cycle of a frame
module vga_timing_engine
    import vga_pkg::*;
#(
    parameter int unsigned COLOR_W = 8,
    parameter int unsigned CNT_W   = 12,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BACK  = 48,
    parameter int unsigned H_ACT   = 640,
    parameter int unsigned H_FRONT = 16,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BACK  = 33,
    parameter int unsigned V_ACT   = 480,
    parameter int unsigned V_FRONT = 10,
    parameter logic        HS_POL  = 1'b0,
    parameter logic        VS_POL  = 1'b0,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iEN,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               iPATTERN,
`endif
    input  logic [COLOR_W-1:0] iRed,
    input  logic [COLOR_W-1:0] iGreen,
    input  logic [COLOR_W-1:0] iBlue,
    output logic               oREQ,
    output logic [CNT_W-1:0]   oX,
    output logic [CNT_W-1:0]   oY,
    output logic [COLOR_W-1:0] oVGA_R,
    output logic [COLOR_W-1:0] oVGA_G,
    output logic [COLOR_W-1:0] oVGA_B,
    output logic               oVGA_H_SYNC,
    output logic               oVGA_V_SYNC,
    output logic               oVGA_BLANK,
    output logic               oVGA_SYNC,
    output logic               oVGA_CLK,
    output logic               oFRAME_START
);

    localparam int unsigned H_TOT = H_SYNC + H_BACK + H_ACT + H_FRONT;
    localparam int unsigned V_TOT = V_SYNC + V_BACK + V_ACT + V_FRONT;
    localparam int unsigned H_OFF = H_SYNC + H_BACK;
    localparam int unsigned V_OFF = V_SYNC + V_BACK;
    localparam vga_ctl_t CTL_IDLE = '{active: 1'b0, hs: ~HS_POL, vs: ~VS_POL, fs: 1'b0};

    // Illegal timing configurations stop elaboration.
    if (H_SYNC < 1 || H_BACK < 1 || H_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 || V_FRONT < 1) begin : g_err_porch
        $error("vga_timing_engine: sync and porch widths must be at least 1");
    end
    if (RD_LAT > 4) begin : g_err_lat
        $error("vga_timing_engine: RD_LAT must be 0..4");
    end
    if ((64'(H_TOT) >> CNT_W) != 0 || (64'(V_TOT) >> CNT_W) != 0) begin : g_err_tot
        $error("vga_timing_engine: H_TOT/V_TOT do not fit in CNT_W bits");
    end

    logic [CNT_W-1:0] hCnt, vCnt;
    logic hWrap, hActive, hSyncRaw;
    logic vWrap, vActive, vSyncRaw;
    logic rawActive;
    vga_ctl_t ctlRaw, ctlDly;
    logic [COLOR_W-1:0] colR, colG, colB;
    logic unusedVWrap;

    vga_axis_counter #(.SYNC(H_SYNC), .BACK(H_BACK), .ACT(H_ACT), .FRONT(H_FRONT), .W(CNT_W)) uHCnt (
        .iCLK(iCLK), .iRST_N(iRST_N), .tick(iEN), .clear(~iEN),
        .cnt(hCnt), .wrap(hWrap), .active(hActive), .sync_raw(hSyncRaw)
    );

    vga_axis_counter #(.SYNC(V_SYNC), .BACK(V_BACK), .ACT(V_ACT), .FRONT(V_FRONT), .W(CNT_W)) uVCnt (
        .iCLK(iCLK), .iRST_N(iRST_N), .tick(hWrap), .clear(~iEN),
        .cnt(vCnt), .wrap(vWrap), .active(vActive), .sync_raw(vSyncRaw)
    );

    assign unusedVWrap = vWrap;

    // Request side: everything gated by iEN so a disabled raster looks idle at once.
    assign rawActive = iEN && hActive && vActive;
    assign oREQ      = rawActive;
    assign oX        = rawActive ? CNT_W'(hCnt - CNT_W'(H_OFF)) : '0;
    assign oY        = rawActive ? CNT_W'(vCnt - CNT_W'(V_OFF)) : '0;

    assign ctlRaw = '{active: rawActive,
                      hs:     (iEN && hSyncRaw) ? HS_POL : ~HS_POL,
                      vs:     (iEN && vSyncRaw) ? VS_POL : ~VS_POL,
                      fs:     iEN && (hCnt == '0) && (vCnt == '0)};

    // Read-latency compensation for the control flags.
    if (RD_LAT == 0) begin : g_ctl_nopipe
        assign ctlDly = ctlRaw;
    end else begin : g_ctl_pipe
        vga_ctl_t pipe [RD_LAT];
        always_ff @(posedge iCLK or negedge iRST_N) begin
            if (!iRST_N) begin
                for (int i = 0; i < int'(RD_LAT); i++) pipe[i] <= CTL_IDLE;
            end else begin
                pipe[0] <= ctlRaw;
                for (int i = 1; i < int'(RD_LAT); i++) pipe[i] <= pipe[i-1];
            end
        end
        assign ctlDly = pipe[RD_LAT-1];
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned BAR_W = (H_ACT / NUM_BARS > 0) ? H_ACT / NUM_BARS : 1;
    logic [CNT_W-1:0] barWide;
    logic [2:0]       barIdx;
    logic [3:0]       patRaw, patDly;   // {pattern select, r, g, b}

    assign barWide = oX / CNT_W'(BAR_W);
    assign barIdx  = (barWide > CNT_W'(NUM_BARS - 1)) ? 3'(NUM_BARS - 1) : barWide[2:0];
    assign patRaw  = {iPATTERN, bar_color(barIdx)};

    // Bars ride the same latency as the control flags.
    if (RD_LAT == 0) begin : g_pat_nopipe
        assign patDly = patRaw;
    end else begin : g_pat_pipe
        logic [3:0] pipe [RD_LAT];
        always_ff @(posedge iCLK or negedge iRST_N) begin
            if (!iRST_N) begin
                for (int i = 0; i < int'(RD_LAT); i++) pipe[i] <= '0;
            end else begin
                pipe[0] <= patRaw;
                for (int i = 1; i < int'(RD_LAT); i++) pipe[i] <= pipe[i-1];
            end
        end
        assign patDly = pipe[RD_LAT-1];
    end

    assign colR = patDly[3] ? {COLOR_W{patDly[2]}} : iRed;
    assign colG = patDly[3] ? {COLOR_W{patDly[1]}} : iGreen;
    assign colB = patDly[3] ? {COLOR_W{patDly[0]}} : iBlue;
`else
    assign colR = iRed;
    assign colG = iGreen;
    assign colB = iBlue;
`endif

    // Pin register.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            oVGA_R       <= '0;
            oVGA_G       <= '0;
            oVGA_B       <= '0;
            oVGA_BLANK   <= 1'b0;
            oVGA_H_SYNC  <= ~HS_POL;
            oVGA_V_SYNC  <= ~VS_POL;
            oFRAME_START <= 1'b0;
        end else begin
            oVGA_R       <= ctlDly.active ? colR : '0;
            oVGA_G       <= ctlDly.active ? colG : '0;
            oVGA_B       <= ctlDly.active ? colB : '0;
            oVGA_BLANK   <= ctlDly.active;
            oVGA_H_SYNC  <= ctlDly.hs;
            oVGA_V_SYNC  <= ctlDly.vs;
            oFRAME_START <= ctlDly.fs;
        end
    end

    assign oVGA_SYNC = 1'b0;
    assign oVGA_CLK  = ~iCLK;

endmodule
